// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the fetch/data memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_F      = 2'd1;
    localparam logic [1:0] OWN_D      = 2'd2;
    localparam int         WORD_SHIFT = 2;

    // Only the two lowest byte-address bits matter for word alignment.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter with one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0 = requester 0 granted last, 1 = requester 1 granted last
    logic r_last_grant;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_last_grant ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (|w_gnt) begin
            r_last_grant <= w_gnt[1];
        end
    end

    assign gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between fetch and data ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_req,
    input  logic [ADDRESS_WIDTH-1:0] f_addr,
    output logic                     f_ack,
    output logic                     f_err,
    output logic                     f_rvalid,
    output logic [DATA_WIDTH-1:0]    f_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_ack,
    output logic                     d_err,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [CNT_WIDTH-1:0]     conflict_count
);

    logic [1:0]               w_req;
    logic [1:0]               w_gnt;
    logic                     w_f_gnt;
    logic                     w_d_gnt;
    logic                     w_f_aligned;
    logic                     w_d_aligned;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [ADDRESS_WIDTH-1:0] w_word_addr;
    logic [1:0]               w_pend_next;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [1:0]               r_pend_owner;
    logic [CNT_WIDTH-1:0]     r_conflict_count;

    // Requests are masked during reset so nothing is granted or written.
    assign w_req = {d_req, f_req} & {2{~reset}};

    rr_arbiter2 u_rr_arbiter2 (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign w_f_gnt     = w_gnt[0];
    assign w_d_gnt     = w_gnt[1];
    assign w_f_aligned = is_aligned(f_addr[1:0]);
    assign w_d_aligned = is_aligned(d_addr[1:0]);

    assign f_ack = w_f_gnt;
    assign d_ack = w_d_gnt;
    assign f_err = w_f_gnt & ~w_f_aligned;
    assign d_err = w_d_gnt & ~w_d_aligned;

    assign w_sel_addr  = w_d_gnt ? d_addr : f_addr;
    assign w_word_addr = w_sel_addr >> WORD_SHIFT;

    // Idle cycles replay the last address so memory read data stays stable.
    assign mem_addr  = (w_f_gnt | w_d_gnt) ? w_word_addr : r_mem_addr;
    assign mem_we    = w_d_gnt & d_we & w_d_aligned;
    assign mem_wdata = d_wdata;

    always_comb begin
        w_pend_next = OWN_NONE;
        if (w_f_gnt && w_f_aligned) begin
            w_pend_next = OWN_F;
        end else if (w_d_gnt && w_d_aligned && !d_we) begin
            w_pend_next = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr       <= '0;
            r_pend_owner     <= OWN_NONE;
            r_conflict_count <= '0;
        end else begin
            r_mem_addr   <= mem_addr;
            r_pend_owner <= w_pend_next;
            if (f_req && d_req && !(&r_conflict_count)) begin
                r_conflict_count <= r_conflict_count + 1'b1;
            end
        end
    end

    // Gating with reset drops a response whose grant was just flushed.
    assign f_rvalid = (r_pend_owner == OWN_F) & ~reset;
    assign d_rvalid = (r_pend_owner == OWN_D) & ~reset;
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    assign conflict_count = r_conflict_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        logic        fv;
        logic        dv;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack, f_err, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req, d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack, d_err, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_count;

    logic [31:0] ram       [0:65535];
    logic [31:0] model_mem [0:65535];

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];

    logic        m_last;
    logic [15:0] m_cnt;
    logic [15:0] m_addr;
    logic        m_known;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .f_req          (f_req),
        .f_addr         (f_addr),
        .f_ack          (f_ack),
        .f_err          (f_err),
        .f_rvalid       (f_rvalid),
        .f_rdata        (f_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ack          (d_ack),
        .d_err          (d_err),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .conflict_count (conflict_count)
    );

    // Synchronous single-port RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the reference model, advance it.
    task automatic cyc(input logic rst, input logic fr, input logic [15:0] fa,
                       input logic dr, input logic dw, input logic [15:0] da,
                       input logic [31:0] wd);
        exp_t e, n;
        logic ef, ed, f_al, d_al, ewe;
        logic [15:0] eaddr;
        @(negedge clk);
        reset = rst; f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin e.fv = 1'b0; e.dv = 1'b0; e.data = '0; end
        if (rst) begin e.fv = 1'b0; e.dv = 1'b0; end
        ef = 1'b0; ed = 1'b0;
        if (!rst) begin
            if (fr && dr) begin ef = m_last; ed = ~m_last; end
            else begin ef = fr; ed = dr; end
        end
        f_al  = (fa[1:0] == 2'b00);
        d_al  = (da[1:0] == 2'b00);
        ewe   = ed & dw & d_al;
        eaddr = ef ? (fa >> 2) : (ed ? (da >> 2) : m_addr);

        check_val("f_ack", {31'd0, f_ack}, {31'd0, ef});
        check_val("d_ack", {31'd0, d_ack}, {31'd0, ed});
        check_val("f_err", {31'd0, f_err}, {31'd0, ef & ~f_al});
        check_val("d_err", {31'd0, d_err}, {31'd0, ed & ~d_al});
        check_val("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        check_val("mem_wdata", mem_wdata, wd);
        if (m_known || ef || ed) check_val("mem_addr", {16'd0, mem_addr}, {16'd0, eaddr});
        if (m_known) check_val("conflict_count", {16'd0, conflict_count}, {16'd0, m_cnt});
        check_val("f_rvalid", {31'd0, f_rvalid}, {31'd0, e.fv});
        check_val("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.dv});
        check_val("f_rdata", f_rdata, e.fv ? e.data : 32'd0);
        check_val("d_rdata", d_rdata, e.dv ? e.data : 32'd0);

        n.fv = 1'b0; n.dv = 1'b0; n.data = '0;
        if (ef && f_al) begin n.fv = 1'b1; n.data = model_mem[fa >> 2]; end
        else if (ed && d_al && !dw) begin n.dv = 1'b1; n.data = model_mem[da >> 2]; end
        exp_q.push_back(n);

        if (rst) begin
            m_last = 1'b1; m_cnt = '0; m_addr = '0; m_known = 1'b1;
        end else begin
            if (ef || ed) begin m_last = ed; m_addr = eaddr; end
            if (fr && dr && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (ewe) model_mem[da >> 2] = wd;
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]       = 32'hA500_0000 + i;
            model_mem[i] = 32'hA500_0000 + i;
        end
        reset = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;
        m_last = 1'b1; m_cnt = '0; m_addr = '0; m_known = 1'b0;

        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);

        // Single fetch
        cyc(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h0, 32'h0);
        check_val("fetch8_addr", {16'd0, mem_addr}, 32'h0000_0002);
        idle();
        check_val("fetch8_data", f_rdata, 32'hA500_0002);

        // Conflict sequence right after reset
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0004, 32'h0);
        check_val("c1_fack", {31'd0, f_ack}, 32'd1);
        cyc(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0004, 32'h0);
        check_val("c2_dack", {31'd0, d_ack}, 32'd1);
        cyc(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0004, 32'h0);
        check_val("c3_fack", {31'd0, f_ack}, 32'd1);
        idle();
        check_val("cnt3", {16'd0, conflict_count}, 32'd3);

        // Store then fetch back
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
        idle();
        check_val("store_readback", f_rdata, 32'hDEAD_BEEF);

        // Misaligned store, then confirm word 1 untouched
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0006, 32'h1234_5678);
        cyc(1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 32'h0);
        idle();
        check_val("word1_intact", f_rdata, 32'hA500_0001);

        // Pipelined fetches
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'(i * 4), 1'b0, 1'b0, 16'h0, 32'h0);
        idle();

        // Data loads, misaligned fetch, loads interleaved with fetches
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h000C, 32'h0);
        cyc(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0024, 32'h0);
        cyc(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0024, 32'h0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 32'h0);
        idle();

        // Reset flushes an in-flight fetch; fetch wins the next conflict
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0008, 32'h0);
        check_val("rst_no_rvalid", {31'd0, f_rvalid}, 32'd0);
        cyc(1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0008, 32'h0);
        check_val("post_rst_fack", {31'd0, f_ack}, 32'd1);
        check_val("post_rst_cnt", {16'd0, conflict_count}, 32'd0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
